dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and
//  off-chip data memory. Replaces the zero-latency data memory port: hits complete in the
//  access cycle; misses raise p1_stall_o, freezing all pipeline registers, until the line is resident.
// PARAMETERS
//  LINES      32  number of cache lines (power of 2); index = addr[4+log2(LINES):5]
//  ADDR_W     32  byte address width; tag = addr[ADDR_W-1:5+log2(LINES)]
//  LINE_W    256  line width in bits (8 x 32-bit words, fixed; word select = addr[4:2])
// PORTS
//  clk_i           in   1       clock
//  rst_i           in   1       asynchronous reset, active-low
//  p1_req_i        in   1       MEM-stage access valid (MemRead | MemWrite)
//  p1_write_i      in   1       1 = store, 0 = load
//  p1_addr_i       in   ADDR_W  byte address (addr[1:0] ignored)
//  p1_data_i       in   32      store data
//  p1_data_o       out  32      load data, valid when p1_req_i & !p1_stall_o
//  p1_stall_o      out  1       pipeline freeze request
//  mem_enable_o    out  1       memory request valid, held until mem_ack_i
//  mem_write_o     out  1       1 = line write-back, 0 = line fetch
//  mem_addr_o      out  ADDR_W  line-aligned address (addr[4:0] = 0)
//  mem_data_o      out  LINE_W  write-back line
//  mem_data_i      in   LINE_W  fetched line, valid with mem_ack_i
//  mem_ack_i       in   1       one-cycle completion pulse
// BEHAVIOUR
//  Reset (async, rst_i=0): state=IDLE, all valid/dirty bits 0, mem_enable_o=0, mem_write_o=0,
//   mem_addr_o=0, p1_stall_o=0, p1_data_o=0; data/tag arrays not cleared.
//  hit = p1_req_i & valid[idx] & (tag[idx]==addr_tag). p1_stall_o = p1_req_i & !(hit & state==IDLE).
//  Load hit: p1_data_o combinational from selected word, zero extra latency.
//  Store hit: word written, dirty[idx]=1 at the rising edge of the access cycle.
//  FSM: IDLE -> (req & !hit & dirty victim) WRITEBACK; (req & !hit & clean) ALLOCATE.
//   WRITEBACK: mem_enable_o=1, mem_write_o=1, addr={victim tag,idx,5'b0}, data=victim line;
//    on mem_ack_i -> ALLOCATE. ALLOCATE: mem_enable_o=1, mem_write_o=0, addr={tag,idx,5'b0};
//    on mem_ack_i capture line, valid=1, dirty=0, tag updated -> REFILL.
//   REFILL: one cycle, enable low; -> IDLE, where the retried access hits (store then merges, dirty=1).
//  Miss penalty clean = ack latency + 2 cycles; dirty adds write-back ack latency.
//  mem_enable_o/mem_addr_o/mem_data_o stable from request until the ack cycle inclusive.
//  mem_ack_i in IDLE/REFILL ignored. p1_req_i dropped mid-miss: transaction completes, no abort.
//  Address/data sampled at miss entry; inputs stable while stalled (pipeline frozen).
//  Reset mid-transaction: FSM to IDLE immediately, enable dropped, line stays invalid.
// CONFIGURATION
//  DCACHE_STATS_EN defined: 32-bit saturating counters hit_cnt_o, miss_cnt_o, wb_cnt_o added as
//   outputs; hit counted per non-stalled access, miss per IDLE->miss exit, wb per write-back ack;
//   reset to 0. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  dcache_pkg: state enum {IDLE,WRITEBACK,ALLOCATE,REFILL}, LINE_W, WORD_SEL_W, OFFSET_W=5,
//   address-field extract functions.
//  Sub-module dcache_sram: tag + data arrays, per-word write enable, full-line write port,
//   combinational read; valid/dirty flops live in dcache_controller for async reset.
// TESTING
//  Cold load 0x0000_0040, memory acks after 4 cycles -> stall 6 cycles, mem_addr_o=0x40,
//   mem_write_o=0, then p1_data_o=mem word 0.
//  Repeat load 0x44 after refill -> stall=0, data = word 1 same cycle, no mem_enable_o.
//  Store 0xDEADBEEF to 0x48 (hit), then load 0x1048 (same idx, new tag) -> WRITEBACK to
//   0x40 with word 2=0xDEADBEEF, then ALLOCATE 0x1040.
//  Store miss to clean line 0x2000 -> fetch 0x2000, merge word 0, dirty set; next evict writes back.
//  Drop p1_req_i during ALLOCATE; assert rst_i=0 mid-WRITEBACK -> enable low same cycle,
//   state IDLE, all lines miss.
//  With DCACHE_STATS_EN: above sequence -> hit_cnt_o/miss_cnt_o/wb_cnt_o match scoreboard.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg -- shared types and constants for the data cache controller.
//   state_t / S_*  : controller FSM encoding
//   LINE_W         : cache line width (8 x 32-bit words)
//   WORD_SEL_W     : bits selecting a word within a line (addr[4:2])
//   OFFSET_W       : byte offset bits within a line (addr[4:0])
//   word_of()      : extract one 32-bit word from a line
//   line_offset()  : all-zero byte offset used to form line-aligned addresses
package dcache_pkg;

    localparam int WORD_W     = 32;
    localparam int WORDS      = 8;
    localparam int LINE_W     = WORD_W * WORDS;
    localparam int WORD_SEL_W = 3;
    localparam int OFFSET_W   = 5;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE      = 2'd0;
    localparam state_t S_WRITEBACK = 2'd1;
    localparam state_t S_ALLOCATE  = 2'd2;
    localparam state_t S_REFILL    = 2'd3;

    function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0]     line,
                                                  input logic [WORD_SEL_W-1:0] sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] line_offset();
        return '0;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram -- tag and data storage for the direct-mapped data cache.
//   clk_i         clock
//   idx_i         line index shared by the read and both write ports
//   rd_tag_o      tag stored at idx_i (combinational)
//   rd_line_o     line stored at idx_i (combinational)
//   word_we_i     write one 32-bit word (store hit)
//   word_sel_i    word position for word_we_i
//   word_data_i   word to write
//   line_we_i     write a full line plus its tag (refill)
//   line_tag_i    tag written with the line
//   line_data_i   line to write
// The arrays have no reset; validity is tracked by the controller.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = 5,
    parameter int TAG_W = 22
) (
    input  logic                  clk_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [LINE_W-1:0]     rd_line_o,
    input  logic                  word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     word_data_i,
    input  logic                  line_we_i,
    input  logic [TAG_W-1:0]      line_tag_i,
    input  logic [LINE_W-1:0]     line_data_i
);

    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][word_sel_i*WORD_W +: WORD_W] <= word_data_i;
        end
    end

    assign rd_tag_o  = tag_q[idx_i];
    assign rd_line_o = data_q[idx_i];

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller -- direct-mapped, write-back, write-allocate data cache
// between the MEM stage and off-chip data memory.
//   clk_i, rst_i             clock, asynchronous active-low reset
//   p1_req_i/p1_write_i      pipeline access valid / store
//   p1_addr_i/p1_data_i      byte address / store data
//   p1_data_o/p1_stall_o     load data / pipeline freeze
//   mem_enable_o/mem_write_o memory request valid / write-back (1) or fetch (0)
//   mem_addr_o/mem_data_o    line-aligned address / write-back line
//   mem_data_i/mem_ack_i     fetched line / one-cycle completion
// Optional macro DCACHE_STATS_EN adds saturating hit_cnt_o, miss_cnt_o, wb_cnt_o.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | serve hits; on a miss latch the address and leave
// S_WRITEBACK | write the dirty victim line to memory, wait for ack
// S_ALLOCATE  | fetch the requested line, install it on ack
// S_REFILL    | one settling cycle, then retry the access in S_IDLE
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINES  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       wb_cnt_o
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    logic [ADDR_W-1:0] cur_addr;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              hit;
    logic              idle_hit;
    logic              miss;
    logic              word_we;
    logic              line_we;
    logic              unused_addr_bits;

    // While a miss is outstanding the latched address drives the arrays, so
    // the victim tag and write-back line stay stable for the whole request.
    assign cur_addr = (state_q == S_IDLE) ? p1_addr_i : addr_q;
    assign idx      = cur_addr[OFFSET_W +: IDX_W];
    assign tag      = cur_addr[ADDR_W-1 -: TAG_W];
    assign unused_addr_bits = ^cur_addr[1:0];

    assign hit      = p1_req_i & valid_q[idx] & (rd_tag == tag);
    assign idle_hit = hit & (state_q == S_IDLE);
    assign miss     = p1_req_i & ~hit;

    assign p1_stall_o = p1_req_i & ~idle_hit;
    assign p1_data_o  = idle_hit ? word_of(rd_line, cur_addr[OFFSET_W-1:2]) : '0;

    dcache_sram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_sram (
        .clk_i       (clk_i),
        .idx_i       (idx),
        .rd_tag_o    (rd_tag),
        .rd_line_o   (rd_line),
        .word_we_i   (word_we),
        .word_sel_i  (cur_addr[OFFSET_W-1:2]),
        .word_data_i (p1_data_i),
        .line_we_i   (line_we),
        .line_tag_i  (tag),
        .line_data_i (mem_data_i)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        addr_d  = addr_q;
        word_we = 1'b0;
        line_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    addr_d  = p1_addr_i;
                    state_d = (valid_q[idx] & dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
                end else if (idle_hit & p1_write_i) begin
                    word_we      = 1'b1;
                    dirty_d[idx] = 1'b1;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (mem_ack_i) begin
                    line_we      = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = S_REFILL;
                end
            end
            S_REFILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            addr_q  <= addr_d;
        end
    end

    // Request outputs decode straight from the state register so a reset
    // drops mem_enable_o in the same cycle.
    assign mem_enable_o = (state_q == S_WRITEBACK) | (state_q == S_ALLOCATE);
    assign mem_write_o  = (state_q == S_WRITEBACK);
    assign mem_data_o   = (state_q == S_WRITEBACK) ? rd_line : '0;

    always_comb begin
        mem_addr_o = '0;
        if (state_q == S_WRITEBACK) begin
            mem_addr_o = {rd_tag, idx, line_offset()};
        end else if (state_q == S_ALLOCATE) begin
            mem_addr_o = {tag, idx, line_offset()};
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic [31:0] wb_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (idle_hit && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == S_IDLE) && miss && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if ((state_q == S_WRITEBACK) && mem_ack_i && wb_cnt_q != '1) begin
                wb_cnt_q <= wb_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller -- directed test of dcache_controller against a
// behavioural line memory that acknowledges ACK_LAT cycles after a request.
// Build with +define+DCACHE_STATS_EN to also check the statistics counters.
module tb_dcache_controller;

    localparam int ACK_LAT = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p1_req_i;
    logic         p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
    logic [31:0]  wb_cnt_o;
`endif

    dcache_controller dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_req_i     (p1_req_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o),
        .wb_cnt_o     (wb_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Untouched memory holds each word's own byte address xor a marker.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [255:0] pat_line(input logic [31:0] base);
        logic [255:0] ln;
        for (int w = 0; w < 8; w++) ln[w*32 +: 32] = pat(base + 32'(w * 4));
        return ln;
    endfunction

    logic [255:0] mem_q [logic [31:0]];
    int           n_fetch = 0;
    int           n_wb    = 0;
    int           n_unstable = 0;
    logic [31:0]  last_fetch_addr = '0;
    logic [31:0]  last_wb_addr = '0;
    logic [255:0] last_wb_data = '0;

    // Memory responder: counts enable cycles, acks on the ACK_LAT-th one and
    // checks the request stays stable until then.
    initial begin
        int          lat;
        logic [31:0] req_addr;
        logic        req_wr;
        lat = 0;
        req_addr = '0;
        req_wr = 1'b0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (mem_enable_o && rst_i) begin
                lat++;
                if (lat == 1) begin
                    req_addr = mem_addr_o;
                    req_wr   = mem_write_o;
                end else if (mem_addr_o !== req_addr || mem_write_o !== req_wr) begin
                    n_unstable++;
                end
                if (lat == ACK_LAT) begin
                    lat = 0;
                    mem_ack_i = 1'b1;
                    if (mem_write_o) begin
                        n_wb++;
                        last_wb_addr = mem_addr_o;
                        last_wb_data = mem_data_o;
                        mem_q[mem_addr_o] = mem_data_o;
                    end else begin
                        n_fetch++;
                        last_fetch_addr = mem_addr_o;
                        mem_data_i = mem_q.exists(mem_addr_o) ? mem_q[mem_addr_o] : pat_line(mem_addr_o);
                    end
                end
            end else begin
                lat = 0;
            end
        end
    end

    // One pipeline access: present it, count stalled cycles, return the
    // data seen in the completing cycle, then let that edge pass.
    task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             output int stalls, output logic [31:0] rd);
        p1_req_i   = 1'b1;
        p1_write_i = wr;
        p1_addr_i  = a;
        p1_data_i  = d;
        stalls = 0;
        #1;
        while (p1_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk_i);
            #1;
        end
        if (stalls >= 200) check("stall_bound", p1_stall_o, 1'b0);
        rd = p1_data_o;
        @(negedge clk_i);
        p1_req_i   = 1'b0;
        p1_write_i = 1'b0;
    endtask

    initial begin
        int           st;
        logic [31:0]  rd;
        logic [255:0] exp_line;
        int           f0;

        rst_i = 1'b0;
        p1_req_i = 1'b0;
        p1_write_i = 1'b0;
        p1_addr_i = '0;
        p1_data_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_stall",  p1_stall_o,   1'b0);
        check("rst_enable", mem_enable_o, 1'b0);
        check("rst_write",  mem_write_o,  1'b0);
        check("rst_addr",   mem_addr_o,   32'h0);
        check("rst_data",   p1_data_o,    32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // cold load: 1 miss cycle + 4 ack latency + 1 refill
        do_access(1'b0, 32'h0000_0040, 32'h0, st, rd);
        check("cold_stall", 32'(st), 32'd6);
        check("cold_fetch_addr", last_fetch_addr, 32'h40);
        check("cold_data", rd, 32'h5A5A_0040);
        check("cold_nfetch", 32'(n_fetch), 32'd1);

        do_access(1'b0, 32'h0000_0044, 32'h0, st, rd);
        check("hit_stall", 32'(st), 32'd0);
        check("hit_data", rd, 32'h5A5A_0044);
        check("hit_nofetch", 32'(n_fetch), 32'd1);

        do_access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, st, rd);
        check("store_hit_stall", 32'(st), 32'd0);

        // dirty eviction: 1 + 4 write-back + 4 fetch + 1 refill
        do_access(1'b0, 32'h0000_1048, 32'h0, st, rd);
        exp_line = pat_line(32'h40);
        exp_line[2*32 +: 32] = 32'hDEAD_BEEF;
        check("evict_stall", 32'(st), 32'd10);
        check("evict_wb_addr", last_wb_addr, 32'h40);
        check("evict_wb_data", last_wb_data, exp_line);
        check("evict_fetch_addr", last_fetch_addr, 32'h1040);
        check("evict_data", rd, 32'h5A5A_1048);

        do_access(1'b1, 32'h0000_2000, 32'h1234_5678, st, rd);
        check("store_miss_stall", 32'(st), 32'd6);
        check("store_miss_fetch", last_fetch_addr, 32'h2000);
        do_access(1'b0, 32'h0000_2000, 32'h0, st, rd);
        check("merge_stall", 32'(st), 32'd0);
        check("merge_data", rd, 32'h1234_5678);

        do_access(1'b0, 32'h0000_3000, 32'h0, st, rd);
        exp_line = pat_line(32'h2000);
        exp_line[31:0] = 32'h1234_5678;
        check("evict2_stall", 32'(st), 32'd10);
        check("evict2_wb_addr", last_wb_addr, 32'h2000);
        check("evict2_wb_data", last_wb_data, exp_line);
        check("evict2_data", rd, 32'h5A5A_3000);

        // drop the request two cycles into the miss; the fetch still completes
        f0 = n_fetch;
        p1_req_i = 1'b1;
        p1_write_i = 1'b0;
        p1_addr_i = 32'h0000_4080;
        repeat (2) @(negedge clk_i);
        check("drop_in_alloc", {mem_enable_o, mem_write_o}, 2'b10);
        p1_req_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("drop_nfetch", 32'(n_fetch), 32'(f0 + 1));
        check("drop_fetch_addr", last_fetch_addr, 32'h4080);
        check("drop_idle", mem_enable_o, 1'b0);
        do_access(1'b0, 32'h0000_4084, 32'h0, st, rd);
        check("drop_hit_stall", 32'(st), 32'd0);
        check("drop_hit_data", rd, 32'h5A5A_4084);
        do_access(1'b1, 32'h0000_4080, 32'h0BAD_F00D, st, rd);
        check("dirty_4080_stall", 32'(st), 32'd0);

`ifdef DCACHE_STATS_EN
        check("stats_hit",  hit_cnt_o,  32'd9);
        check("stats_miss", miss_cnt_o, 32'd5);
        check("stats_wb",   wb_cnt_o,   32'd2);
`endif

        // reset in the first write-back cycle
        p1_req_i = 1'b1;
        p1_write_i = 1'b0;
        p1_addr_i = 32'h0000_5080;
        for (int i = 0; i < 20 && !(mem_enable_o && mem_write_o); i++) @(negedge clk_i);
        check("wb_start", {mem_enable_o, mem_write_o}, 2'b11);
        check("wb_start_addr", mem_addr_o, 32'h4080);
        p1_req_i = 1'b0;
        rst_i = 1'b0;
        #1;
        check("rst_mid_enable", mem_enable_o, 1'b0);
        check("rst_mid_write",  mem_write_o,  1'b0);
        check("rst_mid_addr",   mem_addr_o,   32'h0);
        check("rst_mid_stall",  p1_stall_o,   1'b0);
`ifdef DCACHE_STATS_EN
        check("rst_stats", {hit_cnt_o, miss_cnt_o, wb_cnt_o}, 96'h0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // everything invalid now; lines come back clean from memory
        do_access(1'b0, 32'h0000_1048, 32'h0, st, rd);
        check("post_rst_stall", 32'(st), 32'd6);
        check("post_rst_data", rd, 32'h5A5A_1048);
        do_access(1'b0, 32'h0000_4080, 32'h0, st, rd);
        check("lost_store_stall", 32'(st), 32'd6);
        check("lost_store_data", rd, 32'h5A5A_4080);
        check("post_rst_nwb", 32'(n_wb), 32'd2);
`ifdef DCACHE_STATS_EN
        check("post_stats_hit",  hit_cnt_o,  32'd2);
        check("post_stats_miss", miss_cnt_o, 32'd2);
        check("post_stats_wb",   wb_cnt_o,   32'd0);
`endif
        check("mem_req_stable", 32'(n_unstable), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
